// File: rtl/dog_pkg.sv
// Shared constants and types for the toy dog behaviour sequencer.
package dog_pkg;

  localparam int MOOD_W  = 3;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = 255;

  localparam logic [MOOD_W-1:0] SLEEP  = 3'd0;
  localparam logic [MOOD_W-1:0] AWAKE  = 3'd1;
  localparam logic [MOOD_W-1:0] HAPPY  = 3'd2;
  localparam logic [MOOD_W-1:0] HUNGRY = 3'd3;
  localparam logic [MOOD_W-1:0] BARK   = 3'd4;

  typedef enum logic [MOOD_W-1:0] {
    S_SLEEP  = SLEEP,
    S_AWAKE  = AWAKE,
    S_HAPPY  = HAPPY,
    S_HUNGRY = HUNGRY,
    S_BARK   = BARK
  } mood_e;

  // True when this tick is the one that brings the count up to lim.
  function automatic logic tick_hit(input logic tick_ev,
                                    input logic [CNT_W-1:0] cnt,
                                    input int unsigned lim);
    return tick_ev && ((32'(cnt) + 32'd1) == lim);
  endfunction

endpackage

// File: rtl/dog_mood_fsm_edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector; one pulse per input rise.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/dog_mood_fsm.sv
// Toy dog mood sequencer: synchronizes tick/pet/feed and runs the mood FSM on clk.
// Optional build macro DOG_AUTOWAKE_EN: wake from SLEEP after SLEEP_TICKS ticks.
//
//   state  | meaning
//   SLEEP  | eyes closed, waits for pet/feed
//   AWAKE  | idle, counts towards hunger
//   HAPPY  | tail wagging, toggles per tick
//   HUNGRY | counts towards sleep, pet makes it bark
//   BARK   | buzzer on for BARK_TICKS ticks
module dog_mood_fsm
  import dog_pkg::*;
#(
  parameter int unsigned HAPPY_TICKS  = 4,
  parameter int unsigned HUNGRY_TICKS = 12,
  parameter int unsigned BARK_TICKS   = 2,
  parameter int unsigned SLEEP_TICKS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_in,
  input  logic              pet,
  input  logic              feed,
  output logic [MOOD_W-1:0] mood,
  output logic              wag,
  output logic              bark,
  output logic              eyes_open,
  output logic              tick_seen
);

  logic tick_ev;
  logic pet_ev;
  logic feed_ev;

  edge_sync u_sync_tick (.clk(clk), .rst_n(rst_n), .din_i(tick_in), .pulse_o(tick_ev));
  edge_sync u_sync_pet  (.clk(clk), .rst_n(rst_n), .din_i(pet),     .pulse_o(pet_ev));
  edge_sync u_sync_feed (.clk(clk), .rst_n(rst_n), .din_i(feed),    .pulse_o(feed_ev));

  mood_e            state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wag_q, wag_d;
  logic             bark_q, eyes_q, seen_q;

  always_comb begin
    state_d = state_q;
    wag_d   = wag_q;
    if (tick_ev && (cnt_q != CNT_W'(CNT_MAX))) cnt_d = cnt_q + 1'b1;
    else                                       cnt_d = cnt_q;

    case (state_q)
      S_SLEEP: begin
        if (feed_ev || pet_ev) state_d = S_AWAKE;
`ifdef DOG_AUTOWAKE_EN
        else if (tick_hit(tick_ev, cnt_q, SLEEP_TICKS)) state_d = S_AWAKE;
`endif
      end
      S_AWAKE: begin
        if (feed_ev || pet_ev)                           state_d = S_HAPPY;
        else if (tick_hit(tick_ev, cnt_q, HUNGRY_TICKS)) state_d = S_HUNGRY;
      end
      S_HAPPY: begin
        // feed is ignored here, so a pet arriving with it still restarts the timer
        if (pet_ev)                                     cnt_d   = '0;
        else if (tick_hit(tick_ev, cnt_q, HAPPY_TICKS)) state_d = S_AWAKE;
        else if (tick_ev)                               wag_d   = ~wag_q;
      end
      S_HUNGRY: begin
        if (feed_ev)                                    state_d = S_HAPPY;
        else if (pet_ev)                                state_d = S_BARK;
        else if (tick_hit(tick_ev, cnt_q, SLEEP_TICKS)) state_d = S_SLEEP;
      end
      S_BARK: begin
        if (feed_ev)                                   state_d = S_HAPPY;
        else if (tick_hit(tick_ev, cnt_q, BARK_TICKS)) state_d = S_HUNGRY;
      end
      default: state_d = S_SLEEP;
    endcase

    // A transitioning tick is consumed by the move and never counted in the new state.
    if (state_d != state_q) begin
      cnt_d = '0;
      wag_d = (state_d == S_HAPPY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SLEEP;
      cnt_q   <= '0;
      wag_q   <= 1'b0;
      bark_q  <= 1'b0;
      eyes_q  <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wag_q   <= wag_d;
      bark_q  <= (state_d == S_BARK);
      eyes_q  <= (state_d != S_SLEEP);
      seen_q  <= tick_ev;
    end
  end

  assign mood      = state_q;
  assign wag       = wag_q;
  assign bark      = bark_q;
  assign eyes_open = eyes_q;
  assign tick_seen = seen_q;

endmodule

// File: tb/tb_dog_mood_fsm.sv
// Scoreboard bench for dog_mood_fsm with default tick parameters.
module tb_dog_mood_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_in;
  logic       pet;
  logic       feed;
  logic [2:0] mood;
  logic       wag;
  logic       bark;
  logic       eyes_open;
  logic       tick_seen;

  int errors = 0;
  int checks = 0;
  int seen_cnt = 0;

  typedef struct {
    string tag;
    int    m;
    int    w;
  } exp_t;

  exp_t sb[$];

  dog_mood_fsm dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .pet(pet), .feed(feed),
    .mood(mood), .wag(wag), .bark(bark), .eyes_open(eyes_open), .tick_seen(tick_seen)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tick_seen === 1'b1) seen_cnt <= seen_cnt + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input int m, input int w);
    exp_t e;
    e.tag = tag;
    e.m   = m;
    e.w   = w;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".mood"}, int'(mood), e.m);
    chk({e.tag, ".wag"},  int'(wag),  e.w);
    chk({e.tag, ".bark"}, int'(bark), (e.m == 4) ? 1 : 0);
    chk({e.tag, ".eyes"}, int'(eyes_open), (e.m != 0) ? 1 : 0);
  endtask

  task automatic tick_rise();
    tick_in = 1'b1;
    clk_n(3);
    tick_in = 1'b0;
    clk_n(3);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_rise();
  endtask

  task automatic tick_step(input string tag, input int m, input int w);
    push_exp(tag, m, w);
    tick_rise();
    pop_check();
  endtask

  task automatic pet_step(input string tag, input int m, input int w);
    push_exp(tag, m, w);
    pet = 1'b1;
    clk_n(3);
    pet = 1'b0;
    clk_n(3);
    pop_check();
  endtask

  task automatic feed_step(input string tag, input int m, input int w);
    push_exp(tag, m, w);
    feed = 1'b1;
    clk_n(3);
    feed = 1'b0;
    clk_n(3);
    pop_check();
  endtask

  initial begin
    int s0;
    rst_n = 1'b1; tick_in = 1'b0; pet = 1'b0; feed = 1'b0;
    #2 rst_n = 1'b0;
    clk_n(3);
    push_exp("reset", 0, 0);
    pop_check();
    chk("reset.tick_seen", int'(tick_seen), 0);
    rst_n = 1'b1;
    clk_n(2);

    // wake, then a long hold must not cause a second transition
    push_exp("wake", 1, 0);
    pet = 1'b1;
    clk_n(4);
    pop_check();
    push_exp("pet_hold", 1, 0);
    clk_n(1000);
    pop_check();
    pet = 1'b0;
    clk_n(3);

    s0 = seen_cnt;
    ticks(11);
    push_exp("awake_11", 1, 0);
    pop_check();
    push_exp("hungry", 3, 0);
    tick_in = 1'b1;
    clk_n(4);
    pop_check();
    tick_in = 1'b0;
    clk_n(3);
    chk("tick_seen_12", seen_cnt - s0, 12);

    pet_step("bark", 4, 0);
    tick_step("bark_t1", 4, 0);
    tick_step("bark_t2", 3, 0);

    push_exp("prio", 2, 1);
    feed = 1'b1; pet = 1'b1;
    clk_n(3);
    feed = 1'b0; pet = 1'b0;
    clk_n(3);
    pop_check();
    tick_step("wag_t1", 2, 0);
    tick_step("wag_t2", 2, 1);
    tick_step("wag_t3", 2, 0);
    tick_step("happy_out", 1, 0);

    // pet in HAPPY restarts the timer; feed there is ignored
    pet_step("happy2", 2, 1);
    tick_step("h2_t1", 2, 0);
    tick_step("h2_t2", 2, 1);
    pet_step("happy_pet", 2, 1);
    feed_step("happy_feed", 2, 1);
    tick_step("h2_t3", 2, 0);
    tick_step("h2_t4", 2, 1);
    tick_step("h2_t5", 2, 0);
    tick_step("happy2_out", 1, 0);

    ticks(11);
    tick_step("hungry2", 3, 0);
    ticks(7);
    tick_step("asleep", 0, 0);

    ticks(7);
`ifdef DOG_AUTOWAKE_EN
    tick_step("autowake", 1, 0);
`else
    tick_step("no_autowake_8", 0, 0);
    ticks(292);
    push_exp("no_autowake_300", 0, 0);
    pop_check();
    pet_step("wake2", 1, 0);
`endif
    ticks(11);
    tick_step("hungry3", 3, 0);
    pet_step("bark2", 4, 0);

    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push_exp("rst_async", 0, 0);
    pop_check();
    chk("rst_async.tick_seen", int'(tick_seen), 0);
    pet = 1'b1;
    clk_n(2);
    rst_n = 1'b1;
    clk_n(1);
    push_exp("rst_rel1", 0, 0);
    pop_check();
    clk_n(1);
    push_exp("rst_rel2", 0, 0);
    pop_check();
    clk_n(1);
    push_exp("rst_rel3", 1, 0);
    pop_check();
    pet = 1'b0;
    clk_n(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dog_mood_fsm.md
# dog_mood_fsm

Behaviour sequencer for the toy dog, directly downstream of the ripple clock divider. Samples one slow divided clock as a tick source and two user inputs (pet, feed), runs the dog's mood state machine with tick-based timeouts, and drives the wag, bark and eyes outputs. All logic runs on the fast system clock. The divided clock is treated only as asynchronous data, never as a clock.

## Interface
- HAPPY_TICKS, 4: ticks spent in HAPPY before returning to AWAKE
- HUNGRY_TICKS, 12: ticks in AWAKE before becoming HUNGRY
- BARK_TICKS, 2: ticks spent barking
- SLEEP_TICKS, 8: ticks in HUNGRY before falling asleep; also the autowake delay
- All parameters are legal in 1..255; 0 is illegal.

- clk  in  1  system clock (undivided board clock)
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- tick_in  in  1  slow divided clock from the clock divider, asynchronous to clk
- pet  in  1  pet button, active-high level, asynchronous
- feed  in  1  feed button, active-high level, asynchronous
- mood  out  3  current state code
- wag  out  1  tail wag drive
- bark  out  1  buzzer drive
- eyes_open  out  1  eye LED drive
- tick_seen  out  1  one-clk pulse per detected tick, for debug/probing

## Operation
- tick_in, pet and feed each pass through a 2-FF synchronizer plus a rising-edge detector. Each input rising edge yields exactly one 1-clk event (tick_ev, pet_ev, feed_ev).
- A held-high input yields no further events.
- Inputs must be stable for at least 2 clk high and 2 clk low. Shorter glitches may be missed.
- tick_cnt: 8 bits. Cleared on every state change, increments on tick_ev, saturates at 255.
- States and codes: SLEEP=0, AWAKE=1, HAPPY=2, HUNGRY=3, BARK=4.
- Event priority within one cycle: feed_ev > pet_ev > timeout.
- SLEEP: pet_ev or feed_ev -> AWAKE.
- AWAKE: feed_ev or pet_ev -> HAPPY. The tick_ev that brings tick_cnt to HUNGRY_TICKS -> HUNGRY.
- HAPPY: pet_ev clears tick_cnt and stays in HAPPY. feed_ev is ignored. Tick reaching HAPPY_TICKS -> AWAKE.
- HUNGRY: feed_ev -> HAPPY. pet_ev -> BARK. Tick reaching SLEEP_TICKS -> SLEEP.
- BARK: feed_ev -> HAPPY. pet_ev is ignored. Tick reaching BARK_TICKS -> HUNGRY.
- A tick that causes a transition is not counted in the new state.
- Outputs:
  - mood = state code.
  - eyes_open = 0 only in SLEEP.
  - bark = 1 only in BARK.
  - wag = 0 outside HAPPY. On entry to HAPPY it is 1, then it toggles on each tick_ev while in HAPPY.
- Reset values: mood=0 (SLEEP), wag=0, bark=0, eyes_open=0, tick_seen=0, tick_cnt=0, all synchronizer flops 0.

## Timing
- Input rising edge to event: the event is high in the 2nd or 3rd clk cycle after the edge, depending on the sampling phase.
- Event to outputs: all outputs are registered and update on the same edge as the state register. They are visible 1 clk after the event cycle.
- Worst-case input edge to output change: 4 clk.
- tick_seen is tick_ev registered: 1 clk wide, 1 clk after tick_ev.
- Reset mid-operation: all outputs and counters take their reset values immediately and asynchronously. The first event is possible 2 clk after rst_n deasserts.
- Simultaneous tick_ev and a higher-priority event: the event wins and tick_cnt is cleared, not incremented.

## Configuration
- DOG_AUTOWAKE_EN defined: in SLEEP, the tick_ev that brings tick_cnt to SLEEP_TICKS -> AWAKE, with no user event needed.
- Not defined: SLEEP is left only on pet_ev or feed_ev, and tick_cnt merely saturates.

## Structure
- Package dog_pkg holds:
  - state code localparams (SLEEP..BARK)
  - MOOD_W=3
  - CNT_W=8
  - CNT_MAX=255
- Sub-module edge_sync (2-FF synchronizer + rising-edge detect, one 1-bit input, one pulse output, clk/rst_n). It is instantiated three times.
- The remainder is a single FSM plus counter plus output register process.

## Test plan
- Reset: drive to BARK, assert rst_n low between clk edges -> mood=0, bark=0, eyes_open=0 immediately. No event earlier than 2 clk after release.
- Wake: in SLEEP, raise pet for 10 clk -> mood=1 and eyes_open=1 within 4 clk of the edge. Holding pet high for 1000 clk produces no further transition.
- Hunger timeout (HUNGRY_TICKS=12): from AWAKE, 11 tick_in rises -> mood still 1. The 12th rise -> mood=3 within 4 clk. tick_seen shows 12 pulses.
- Bark: in HUNGRY, pet -> mood=4, bark=1. After exactly 2 tick rises -> mood=3, bark=0.
- Priority and wag: in HUNGRY, feed and pet rising in the same clk -> mood=2 and wag=1. Wag toggles on ticks 1, 2 and 3. The 4th tick -> mood=1 and wag=0.
- Autowake: in SLEEP with no events, 8 tick rises. With DOG_AUTOWAKE_EN -> mood=1. Without it -> mood stays 0 after 300 ticks.
